// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults and colour helpers for the vga_timing_gen slice.
package vga_timing_gen_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam logic        DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_PIPE_DLY = 2;

    localparam int unsigned COORD_W   = 10;
    localparam logic [7:0]  COL_BLACK = 8'h00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // RRRGGGBB -> 8 bits per channel by bit replication
    function automatic rgb_t expand_rgb(input logic [7:0] c);
        rgb_t o;
        o.r = {c[7:5], c[7:5], c[7:6]};
        o.g = {c[4:2], c[4:2], c[4:3]};
        o.b = {4{c[1:0]}};
        return o;
    endfunction

    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Renderer and DAC signal bundle of vga_timing_gen; test_pattern exists only with VGA_TEST_PATTERN_EN.
interface vga_timing_gen_if;
    logic [7:0] pixel_color;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       frame_start;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_pattern;

    modport master (
        input  pixel_color, test_pattern,
        output x, y, active, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
    );
    modport slave (
        output pixel_color, test_pattern,
        input  x, y, active, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
    );
`else
    modport master (
        input  pixel_color,
        output x, y, active, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
    );
    modport slave (
        output pixel_color,
        input  x, y, active, frame_start, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
    );
`endif
endinterface

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with asynchronous reset to a configurable value.
module vga_pipe_delay #(
    parameter int unsigned           WIDTH     = 1,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync decode aligned to renderer latency, and DAC output register.
// Optional bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    logic [COORD_W-1:0] x_q, y_q;
    logic               frame_q;
    logic               active, hs_raw, vs_raw;
    logic [2:0]         raw, dly;
    logic [7:0]         src_col;
    rgb_t               px, rgb_q;
    logic               hs_q, vs_q, blank_n_q;

    // frame_start marks a wrap only, so the first frame after reset never flags
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (x_q == H_LAST) begin
                x_q <= '0;
                if (y_q == V_LAST) begin
                    y_q     <= '0;
                    frame_q <= 1'b1;
                end else begin
                    y_q <= y_q + 1'b1;
                end
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    always_comb begin
        active = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
        hs_raw = in_window(x_q, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_raw = in_window(y_q, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        raw    = {hs_raw, vs_raw, active};
    end

    vga_pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_sync_dly (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .din   (raw),
        .dout  (dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;

    vga_pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (3'b000)
    ) u_bar_dly (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .din   (x_q[8:6]),
        .dout  (bar_idx)
    );

    always_comb src_col = bus.test_pattern ? {bar_idx, bar_idx, bar_idx[2:1]} : bus.pixel_color;
`else
    always_comb src_col = bus.pixel_color;
`endif

    always_comb px = dly[0] ? expand_rgb(src_col) : expand_rgb(COL_BLACK);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= dly[2];
            vs_q      <= dly[1];
            blank_n_q <= dly[0];
            rgb_q     <= px;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.active      = active;
    assign bus.frame_start = frame_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;

endmodule
